// File: rtl/exc_vector_loader_pkg.sv
// Shared types and codes for the exception vector sequencer.
// The iord_sel codes are also used by the address mux and control unit.
package exc_vector_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_WAIT = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_OPCODE = 2'd1,
        CAUSE_OVF    = 2'd2,
        CAUSE_DIV0   = 2'd3
    } cause_t;

    localparam logic [2:0] IORD_PC   = 3'b000;
    localparam logic [2:0] IORD_ALU  = 3'b001;
    localparam logic [2:0] IORD_V253 = 3'b010;
    localparam logic [2:0] IORD_V254 = 3'b011;
    localparam logic [2:0] IORD_V255 = 3'b100;
    localparam logic [2:0] IORD_MDR  = 3'b101;

    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    // Simultaneous events resolve opcode > overflow > div0.
    function automatic cause_t pick_cause(
        input logic opc,
        input logic ovf,
        input logic div0
    );
        cause_t c;
        c = CAUSE_NONE;
        if (opc) begin
            c = CAUSE_OPCODE;
        end else if (ovf) begin
            c = CAUSE_OVF;
        end else if (div0) begin
            c = CAUSE_DIV0;
        end
        return c;
    endfunction

    function automatic logic [2:0] vec_sel(input cause_t c);
        logic [2:0] s;
        unique case (c)
            CAUSE_OPCODE: s = IORD_V253;
            CAUSE_OVF:    s = IORD_V254;
            CAUSE_DIV0:   s = IORD_V255;
            default:      s = IORD_PC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exc_vector_loader_wait_counter.sv
// Loadable down-counter with zero flag for memory-latency wait states.
// Load has priority over decrement; decrement saturates at zero.
module exc_vector_loader_wait_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/exc_vector_loader.sv
// Exception sequencer: saves EPC, steers iord_sel to the vector slot,
// waits out memory latency and loads PC with the vector byte.
module exc_vector_loader
    import exc_vector_loader_pkg::*;
#(
    parameter int          MEM_WAIT   = 1,
    parameter logic [31:0] EPC_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  iord_sel,
    output logic [31:0] epc_out,
    output logic        epc_write,
    output logic [31:0] pc_out,
    output logic        pc_write,
    output logic [1:0]  cause_out,
    output logic        busy
);

    state_t      state_q, state_d;
    cause_t      cause_q, cause_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] pc_q, pc_d;
    logic        epc_wr_q, epc_wr_d;
    logic        pc_wr_q, pc_wr_d;
    logic        busy_q, busy_d;

    logic        cnt_load, cnt_dec, cnt_zero;
    logic [2:0]  cnt;
    logic        wait_done;
    logic        any_exc;
    cause_t      new_cause;
    logic        unused_hi;

    assign unused_hi = ^mem_data_in[31:8];

    exc_vector_loader_wait_counter #(
        .W (3)
    ) u_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (3'(MEM_WAIT)),
        .dec      (cnt_dec),
        .count    (cnt),
        .zero     (cnt_zero)
    );

    assign any_exc   = exc_opcode | exc_overflow | exc_div0;
    assign new_cause = pick_cause(exc_opcode, exc_overflow, exc_div0);
    // Zero also exits so a stray count can never stall the core.
    assign wait_done = (cnt == 3'd1) | cnt_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cause_q  <= CAUSE_NONE;
            sel_q    <= IORD_PC;
            epc_q    <= '0;
            pc_q     <= '0;
            epc_wr_q <= 1'b0;
            pc_wr_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            sel_q    <= sel_d;
            epc_q    <= epc_d;
            pc_q     <= pc_d;
            epc_wr_q <= epc_wr_d;
            pc_wr_q  <= pc_wr_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        sel_d    = sel_q;
        epc_d    = epc_q;
        pc_d     = pc_q;
        epc_wr_d = 1'b0;
        pc_wr_d  = 1'b0;
        busy_d   = busy_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sel_d  = IORD_PC;
                busy_d = 1'b0;
                if (any_exc) begin
                    state_d  = ST_SAVE;
                    cause_d  = new_cause;
                    sel_d    = vec_sel(new_cause);
                    epc_d    = pc_in - EPC_OFFSET;
                    epc_wr_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_SAVE: begin
                state_d  = ST_WAIT;
                cnt_load = 1'b1;
            end
            ST_WAIT: begin
                // Byte is captured on the edge that enters LOAD.
                if (wait_done) begin
                    state_d = ST_LOAD;
                    pc_d    = {24'b0, mem_data_in[7:0]};
                    pc_wr_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
                sel_d   = IORD_PC;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign iord_sel  = sel_q;
    assign epc_out   = epc_q;
    assign epc_write = epc_wr_q;
    assign pc_out    = pc_q;
    assign pc_write  = pc_wr_q;
    assign cause_out = cause_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_exc_vector_loader.sv
// Randomized bench for exc_vector_loader with MEM_WAIT = 1 and 3,
// checked against a timeline model of each exception sequence.
module tb_exc_vector_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] mem_data_in = '0;

    logic [2:0]  sel  [2];
    logic [31:0] epc  [2];
    logic        epcw [2];
    logic [31:0] pco  [2];
    logic        pcw  [2];
    logic [1:0]  cause[2];
    logic        bsy  [2];

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    exc_vector_loader #(.MEM_WAIT(1), .EPC_OFFSET(32'd4)) u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_in        (pc_in),
        .mem_data_in  (mem_data_in),
        .iord_sel     (sel[0]),
        .epc_out      (epc[0]),
        .epc_write    (epcw[0]),
        .pc_out       (pco[0]),
        .pc_write     (pcw[0]),
        .cause_out    (cause[0]),
        .busy         (bsy[0])
    );

    exc_vector_loader #(.MEM_WAIT(3), .EPC_OFFSET(32'd4)) u_dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .pc_in        (pc_in),
        .mem_data_in  (mem_data_in),
        .iord_sel     (sel[1]),
        .epc_out      (epc[1]),
        .epc_write    (epcw[1]),
        .pc_out       (pco[1]),
        .pc_write     (pcw[1]),
        .cause_out    (cause[1]),
        .busy         (bsy[1])
    );

    // Model: a sequence accepted at edge s runs SAVE in cycle s,
    // WAIT for mw cycles, LOAD in cycle s+mw+1, IDLE again at s+mw+2.
    int          mw  [2] = '{1, 3};
    bit          act [2];
    int          st  [2];
    logic [1:0]  cz  [2];
    logic [2:0]  vz  [2];
    logic [31:0] ez  [2];
    logic [31:0] pz  [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            act[d] = 1'b0;
            st[d]  = 0;
            cz[d]  = 2'd0;
            vz[d]  = 3'd0;
            ez[d]  = '0;
            pz[d]  = '0;
        end
    endtask

    task automatic model_edge(input int e);
        bit idle;
        for (int d = 0; d < 2; d++) begin
            if (act[d] && e == st[d] + mw[d] + 1)
                pz[d] = {24'h0, mem_data_in[7:0]};
            idle = !act[d] || (e >= st[d] + mw[d] + 3);
            if (idle && (exc_opcode || exc_overflow || exc_div0)) begin
                act[d] = 1'b1;
                st[d]  = e;
                ez[d]  = pc_in - 32'd4;
                if (exc_opcode) begin
                    cz[d] = 2'd1; vz[d] = 3'd2;
                end else if (exc_overflow) begin
                    cz[d] = 2'd2; vz[d] = 3'd3;
                end else begin
                    cz[d] = 2'd3; vz[d] = 3'd4;
                end
            end
        end
    endtask

    task automatic check_all(input int c);
        bit b, ew, pw;
        for (int d = 0; d < 2; d++) begin
            b  = act[d] && c >= st[d] && c <= st[d] + mw[d] + 1;
            ew = act[d] && c == st[d];
            pw = act[d] && c == st[d] + mw[d] + 1;
            chk($sformatf("iord_sel[mw%0d]", mw[d]), 32'(sel[d]),
                b ? 32'(vz[d]) : 32'd0);
            chk($sformatf("busy[mw%0d]", mw[d]), 32'(bsy[d]), 32'(b));
            chk($sformatf("epc_write[mw%0d]", mw[d]), 32'(epcw[d]),
                32'(ew));
            chk($sformatf("pc_write[mw%0d]", mw[d]), 32'(pcw[d]),
                32'(pw));
            chk($sformatf("epc_out[mw%0d]", mw[d]), epc[d], ez[d]);
            chk($sformatf("pc_out[mw%0d]", mw[d]), pco[d], pz[d]);
            chk($sformatf("cause_out[mw%0d]", mw[d]), 32'(cause[d]),
                32'(cz[d]));
        end
    endtask

    task automatic tick();
        if (reset_n) model_edge(cyc + 1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_exc(input bit o, input bit v, input bit z);
        exc_opcode   = o;
        exc_overflow = v;
        exc_div0     = z;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        #1;
        model_clear();
        check_all(cyc);
        ticks(n);
        reset_n = 1'b1;
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        do_reset(2);
        ticks(5);

        set_exc(0, 1, 0);
        pc_in = 32'h0000_0108;
        mem_data_in = 32'hAABB_CC40;
        tick();
        set_exc(0, 0, 0);
        ticks(6);

        set_exc(1, 0, 1);
        pc_in = 32'h0000_0020;
        tick();
        set_exc(0, 0, 0);
        ticks(6);

        mem_data_in = 32'h0000_00FF;
        set_exc(0, 0, 1);
        tick();
        set_exc(0, 0, 0);
        tick();
        set_exc(0, 0, 1);
        ticks(2);
        set_exc(0, 0, 0);
        ticks(6);

        set_exc(0, 1, 0);
        pc_in = 32'h0000_1000;
        tick();
        set_exc(0, 0, 0);
        tick();
        do_reset(2);
        ticks(6);

        set_exc(0, 0, 1);
        pc_in = 32'h0000_0000;
        mem_data_in = 32'h1234_5677;
        tick();
        set_exc(0, 0, 0);
        ticks(6);

        for (int i = 0; i < 600; i++) begin
            set_exc($urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0);
            pc_in = ($urandom_range(0, 7) == 0) ?
                    32'($urandom_range(0, 3)) : $urandom;
            mem_data_in = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                tick();
            end
        end
        set_exc(0, 0, 0);
        ticks(6);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
